// File: rtl/truth_table_sequencer_if.sv
// Signal bundle between a truth-table sequencer and the environment driving
// the 2-input gate under test.
interface truth_table_sequencer_if;
  logic       start;
  logic       abort;
  logic [3:0] expected;
  logic       Y;
  logic       A;
  logic       B;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] table_out;
  logic [3:0] err_mask;

  modport master (
    output start, abort, expected, Y,
    input  A, B, busy, done, pass, table_out, err_mask
  );

  modport slave (
    input  start, abort, expected, Y,
    output A, B, busy, done, pass, table_out, err_mask
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Steps {A,B} through 00..11, holds each vector SETTLE_CYCLES cycles, samples Y
// and compares the captured truth table against a latched expected table.
module truth_table_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  truth_table_sequencer_if.slave bus
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned TBL_W    = 4;
  localparam int unsigned IDX_W    = 2;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TBL_W-1:0]   exp_q, exp_d;
  logic [TBL_W-1:0]   tbl_q, tbl_d;
  logic [TBL_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               a_q, a_d;
  logic               b_q, b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; abort wins over the SAMPLE capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    err_d   = err_q;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d   = bus.expected;
          tbl_d   = '0;
          idx_d   = '0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          tbl_d[idx_q] = bus.Y;
          if (idx_q == IDX_LAST) begin
            pass_d  = (tbl_d == exp_q);
            err_d   = tbl_d ^ exp_q;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = SETTLE_LOAD;
            state_d = SETTLE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs follow the next state so they register alongside it
    a_d    = 1'b0;
    b_d    = 1'b0;
    if (state_d == SETTLE || state_d == SAMPLE) begin
      a_d = idx_d[1];
      b_d = idx_d[0];
    end
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.table_out = tbl_q;
  assign bus.err_mask  = err_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: gate models drive Y, run results are
// predicted into a scoreboard queue and checked when done pulses.
module tb_truth_table_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;

  typedef struct packed {
    logic [3:0] tbl;
    logic       pass;
    logic [3:0] err;
  } res_t;

  logic clk;
  logic rst_n;
  logic [3:0] gate0;
  logic [3:0] gate1;

  int n_cmp = 0;
  int n_mis = 0;
  res_t sb[$];
  logic       model_pass;
  logic [3:0] model_err;

  truth_table_sequencer_if ifc0 ();
  truth_table_sequencer_if ifc1 ();

  truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
  truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

  // Combinational gate models
  assign ifc0.Y = gate0[{ifc0.A, ifc0.B}];
  assign ifc1.Y = gate1[{ifc1.A, ifc1.B}];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ab"},   32'({ifc0.A, ifc0.B}), 32'd0);
    chk({tag, "_busy"}, 32'(ifc0.busy), 32'd0);
    chk({tag, "_done"}, 32'(ifc0.done), 32'd0);
    chk({tag, "_pass"}, 32'(ifc0.pass), 32'd0);
    chk({tag, "_tbl"},  32'(ifc0.table_out), 32'd0);
    chk({tag, "_err"},  32'(ifc0.err_mask), 32'd0);
  endtask

  // One run on dut0; restart_k/abort_k give the cycle index (after the start
  // edge) at which start/abort are raised, or -1 for none.
  task automatic run_full(input logic [3:0] tt, input logic [3:0] ex,
                          input int restart_k, input int abort_k);
    res_t r;
    int j;
    logic [3:0] partial;
    gate0 = tt;
    ifc0.expected = ex;
    if (abort_k < 0) begin
      r.tbl  = tt;
      r.pass = (tt == ex);
      r.err  = tt ^ ex;
      sb.push_back(r);
    end
    ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    ifc0.expected = ~ex;
    chk("start_clear_tbl", 32'(ifc0.table_out), 32'd0);
    for (int k = 0; k < 4 * (S0 + 1); k++) begin
      chk("ab_step", 32'({ifc0.A, ifc0.B}), 32'(k / (S0 + 1)));
      chk("busy_run", 32'(ifc0.busy), 32'd1);
      chk("done_early", 32'(ifc0.done), 32'd0);
      if (k == abort_k) begin
        ifc0.abort = 1'b1;
        tick();
        ifc0.abort = 1'b0;
        j = k / (S0 + 1);
        partial = tt & ((4'd1 << j) - 4'd1);
        chk("abort_ab", 32'({ifc0.A, ifc0.B}), 32'd0);
        chk("abort_busy", 32'(ifc0.busy), 32'd0);
        chk("abort_pass", 32'(ifc0.pass), 32'(model_pass));
        chk("abort_err", 32'(ifc0.err_mask), 32'(model_err));
        chk("abort_tbl", 32'(ifc0.table_out), 32'(partial));
        for (int m = 0; m < 4 * (S0 + 1); m++) begin
          chk("abort_no_done", 32'(ifc0.done), 32'd0);
          tick();
        end
        return;
      end
      if (k == restart_k) ifc0.start = 1'b1;
      tick();
      ifc0.start = 1'b0;
    end
    chk("done_pulse", 32'(ifc0.done), 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      r = sb.pop_front();
      chk("res_tbl", 32'(ifc0.table_out), 32'(r.tbl));
      chk("res_pass", 32'(ifc0.pass), 32'(r.pass));
      chk("res_err", 32'(ifc0.err_mask), 32'(r.err));
      model_pass = r.pass;
      model_err  = r.err;
    end
    tick();
    chk("done_one_cycle", 32'(ifc0.done), 32'd0);
    chk("idle_busy", 32'(ifc0.busy), 32'd0);
    chk("idle_ab", 32'({ifc0.A, ifc0.B}), 32'd0);
    chk("hold_pass", 32'(ifc0.pass), 32'(model_pass));
  endtask

  initial begin
    rst_n = 1'b0;
    gate0 = 4'b0001;
    gate1 = 4'b1000;
    ifc0.start = 1'b0; ifc0.abort = 1'b0; ifc0.expected = 4'd0;
    ifc1.start = 1'b0; ifc1.abort = 1'b0; ifc1.expected = 4'd0;
    model_pass = 1'b0;
    model_err  = 4'd0;
    #1;
    chk_reset_outputs("por");
    #12;
    rst_n = 1'b1;
    tick();

    // abort in IDLE does nothing
    ifc0.abort = 1'b1;
    tick();
    ifc0.abort = 1'b0;
    chk("idle_abort_busy", 32'(ifc0.busy), 32'd0);
    chk("idle_abort_ab", 32'({ifc0.A, ifc0.B}), 32'd0);

    // NOR gate, matching and mismatching expectations
    run_full(4'b0001, 4'b0001, -1, -1);
    run_full(4'b0001, 4'b0110, -1, -1);
    // start re-pulsed in SETTLE of idx=1 is ignored
    run_full(4'b0001, 4'b0001, S0 + 1, -1);
    // start right after DONE, then abort during SAMPLE of idx=2
    run_full(4'b0100, 4'b0100, -1, 2 * (S0 + 1) + S0);

    // asynchronous reset mid-SETTLE
    gate0 = 4'b0001;
    ifc0.expected = 4'b0001;
    ifc0.start = 1'b1;
    tick();
    ifc0.start = 1'b0;
    tick();
    chk("pre_reset_busy", 32'(ifc0.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    #3;
    rst_n = 1'b1;
    model_pass = 1'b0;
    model_err  = 4'd0;
    tick();
    chk_reset_outputs("post_rst");
    run_full(4'b0001, 4'b0001, -1, -1);

    // AND gate on SETTLE_CYCLES=1 instance, start and abort together
    ifc1.expected = 4'b1000;
    ifc1.start = 1'b1;
    ifc1.abort = 1'b1;
    tick();
    ifc1.start = 1'b0;
    ifc1.abort = 1'b0;
    for (int k = 0; k < 4 * (S1 + 1); k++) begin
      chk("s1_ab_step", 32'({ifc1.A, ifc1.B}), 32'(k / (S1 + 1)));
      chk("s1_done_early", 32'(ifc1.done), 32'd0);
      tick();
    end
    chk("s1_done", 32'(ifc1.done), 32'd1);
    chk("s1_pass", 32'(ifc1.pass), 32'd1);
    chk("s1_tbl", 32'(ifc1.table_out), 32'b1000);
    chk("s1_err", 32'(ifc1.err_mask), 32'd0);
    tick();
    chk("s1_done_low", 32'(ifc1.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, the number of clock cycles each input vector is held before Y is sampled (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a truth-table run; sampled only in IDLE.
REQ-005 The block SHALL have port abort, input, 1 bit: cancel a run in progress.
REQ-006 The block SHALL have port expected, input, 4 bits: expected truth table, bit i = expected Y for {A,B} = i.
REQ-007 The block SHALL have port Y, input, 1 bit: output of the 2-input gate under sequencing.
REQ-008 The block SHALL have ports A and B, output, 1 bit each, registered: inputs driven to the gate.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse on run completion.
REQ-011 The block SHALL have port pass, output, 1 bit: result of the last completed run.
REQ-012 The block SHALL have port table_out, output, 4 bits: captured truth table, bit i = sampled Y for {A,B} = i.
REQ-013 The block SHALL have port err_mask, output, 4 bits: table_out XOR the latched expected value.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE, a 2-bit vector index idx, and a 4-bit settle counter.
REQ-015 IDLE, start=1: the block SHALL latch expected, clear table_out, set idx=0, load the counter and enter SETTLE.
REQ-016 IDLE, start=0: the block SHALL hold; A=B=0, busy=0.
REQ-017 In SETTLE and SAMPLE, {A,B} SHALL equal idx; A is the MSB.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and write Y into table_out[idx] at its closing edge.
REQ-020 From SAMPLE: if idx<3, the block SHALL increment idx, reload the counter and enter SETTLE.
REQ-021 From SAMPLE: if idx==3, the block SHALL enter DONE, registering pass = (captured table == latched expected) and err_mask = captured table XOR latched expected.
REQ-022 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-023 done SHALL be high exactly 4*(SETTLE_CYCLES+1) rising edges after the edge that samples start; with the default this is 12 edges.
REQ-024 pass, table_out and err_mask SHALL hold their values until the next accepted start.
REQ-025 start SHALL be ignored in SETTLE, SAMPLE and DONE; there is no queuing.
REQ-026 abort=1 in SETTLE or SAMPLE SHALL send the FSM to IDLE at the next edge with A=B=0, no done pulse, and pass/err_mask unchanged.
REQ-027 abort SHALL take priority over the SAMPLE capture in the same cycle.
REQ-028 abort in IDLE or DONE SHALL have no effect; a run that has reached DONE still pulses done.
REQ-029 When start and abort are both high in IDLE, the block SHALL accept start.
REQ-030 Y SHALL be sampled only in SAMPLE; Y changes at any other time SHALL have no effect.

Reset
REQ-031 While rst_n=0, the block SHALL be asynchronously forced to state IDLE, idx=0, counter=0, A=0, B=0, busy=0, done=0, pass=0, table_out=0000, err_mask=0000.
REQ-032 On reset assertion mid-run, all outputs SHALL take their reset values immediately, without waiting for a clock edge, and no done pulse SHALL occur.
REQ-033 After reset release, the first accepted start SHALL begin at idx=0.

Verification
REQ-034 NOR gate model, expected=0001, start pulsed -> {A,B} steps 00,01,10,11, holding each for 3 cycles; done pulses 12 edges after start; table_out=0001, pass=1, err_mask=0000.
REQ-035 NOR gate model, expected=0110 -> done asserts; table_out=0001, pass=0, err_mask=0111.
REQ-036 AND gate model, expected=1000, SETTLE_CYCLES=1 -> done pulses 8 edges after start; pass=1.
REQ-037 start re-pulsed during SETTLE of idx=1 -> ignored; exactly one done pulse; then start in the cycle after DONE -> new run begins and table_out clears to 0000.
REQ-038 abort during SAMPLE of idx=2 -> IDLE next cycle, A=B=0, no done, pass keeps its previous value.
REQ-039 rst_n driven low mid-SETTLE -> all outputs are at reset values before the next clock edge; after release, start launches a clean run.
